// File: rtl/mux_arb.sv
// mux_arb: N-to-1 arbitrating multiplexer with a one-entry registered output stage.
//
// Each cycle one valid input channel is granted, either by round-robin from a
// rotating pointer or by fixed priority (lowest index wins). The granted word
// and its channel index are captured in the output register whenever that
// register is empty or is being drained in the same cycle. This gives a
// throughput of one word per cycle.
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   mode_i       0 = round-robin, 1 = fixed priority
//   in_data_i    N words of WIDTH bits; channel i at [i*WIDTH +: WIDTH]
//   in_valid_i   per-channel offer
//   in_ready_o   per-channel accept (at most one bit high)
//   out_data_o   registered selected word
//   out_sel_o    registered index of the channel that supplied out_data_o
//   out_valid_o  out_data_o/out_sel_o hold a word
//   out_ready_i  downstream accepts the word
module mux_arb #(
   parameter int unsigned N     = 4,
   parameter int unsigned WIDTH = 8,
   localparam int unsigned SW   = $clog2(N)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               mode_i,
   input  logic [N*WIDTH-1:0] in_data_i,
   input  logic [N-1:0]       in_valid_i,
   output logic [N-1:0]       in_ready_o,
   output logic [WIDTH-1:0]   out_data_o,
   output logic [SW-1:0]      out_sel_o,
   output logic               out_valid_o,
   input  logic               out_ready_i
);

   logic [SW-1:0]    ptr_q, ptr_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [SW-1:0]    out_sel_q, out_sel_d;

   logic             load;
   logic             gnt_found;
   logic [SW-1:0]    gnt_idx;
   logic             xfer;
   logic [WIDTH-1:0] gnt_data;

   // The output register can take a new word when it is empty or draining now.
   assign load = !out_valid_q || out_ready_i;
   assign xfer = load && gnt_found;

   // Grant search. Candidate j is visited in search order; in fixed-priority
   // mode the order starts at 0, otherwise it starts at the pointer and wraps.
   always_comb begin
      logic [N-1:0] rot;
      int unsigned  j;
      gnt_found = 1'b0;
      gnt_idx   = '0;
      rot       = '0;
      j         = 0;
      for (int unsigned k = 0; k < N; k++) begin
         if (mode_i) begin
            j = k;
         end else begin
            j = (32'(ptr_q) + k) % N;
         end
         rot = in_valid_i >> j;
         if (!gnt_found && rot[0]) begin
            gnt_found = 1'b1;
            gnt_idx   = SW'(j);
         end
      end
   end

   // Select the granted channel's word.
   always_comb begin
      gnt_data = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (gnt_idx == SW'(i)) begin
            gnt_data = in_data_i[i*WIDTH +: WIDTH];
         end
      end
   end

   // One-hot accept. It is gated by reset so that nothing is accepted while the
   // block is held in reset, even though the output register looks empty.
   always_comb begin
      in_ready_o = '0;
      for (int unsigned i = 0; i < N; i++) begin
         in_ready_o[i] = rst_n && xfer && (gnt_idx == SW'(i));
      end
   end

   always_comb begin
      ptr_d       = ptr_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      if (xfer) begin
         out_valid_d = 1'b1;
         out_data_d  = gnt_data;
         out_sel_d   = gnt_idx;
         if (!mode_i) begin
            ptr_d = (gnt_idx == SW'(N - 1)) ? '0 : gnt_idx + SW'(1);
         end
      end else if (out_ready_i) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
      end else begin
         ptr_q       <= ptr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;
   assign out_sel_o   = out_sel_q;

endmodule

// File: doc/mux_arb.md
MUX_ARB -- requirements
Module: mux_arb

Interface
REQ-001 The block SHALL have parameter N, default 4: number of input channels, legal 2..16.
REQ-002 The block SHALL have parameter WIDTH, default 8: data bits per channel, legal 1..64.
REQ-003 The block SHALL derive SW = $clog2(N) for the select width.
REQ-004 The block SHALL have these ports:
- CLK  input  1: single clock; all state updates on the rising edge.
- RST_N  input  1: reset, asynchronous, active-low.
- MODE  input  1: 0 = round-robin, 1 = fixed priority (lowest index wins).
- IN_DATA  input  N*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
- IN_VALID  input  N: channel i offers a word.
- IN_READY  output  N: channel i's word is accepted this cycle.
- OUT_DATA  output  WIDTH: registered selected word.
- OUT_SEL  output  SW: registered index of the channel that supplied OUT_DATA.
- OUT_VALID  output  1: OUT_DATA/OUT_SEL hold a word.
- OUT_READY  input  1: downstream accepts the word.

Function
REQ-005 Transfer rule: an input transfer SHALL occur on channel i when IN_VALID[i] and IN_READY[i] are both high at a rising edge.
REQ-006 Transfer rule: an output transfer SHALL occur when OUT_VALID and OUT_READY are both high at a rising edge.
REQ-007 The block SHALL hold a one-entry output register.
REQ-008 LOAD = !OUT_VALID | OUT_READY.
REQ-009 A grant SHALL be computed combinationally each cycle from IN_VALID, MODE and the priority pointer PTR (SW bits).
REQ-010 IN_READY[g] SHALL be high only for the granted channel g, and only when LOAD is high; all other bits SHALL be 0.
REQ-011 At most one IN_READY bit SHALL be high in any cycle.
REQ-012 In round-robin mode, the grant SHALL go to the first valid channel found searching PTR, PTR+1, ... modulo N; the search wraps from N-1 to 0.
REQ-013 In fixed-priority mode, the grant SHALL go to the lowest-indexed valid channel; PTR SHALL be ignored.
REQ-014 On an input transfer from channel g in round-robin mode, PTR SHALL become (g+1) mod N.
REQ-015 On an input transfer from channel g in fixed-priority mode, PTR SHALL be left unchanged.
REQ-016 On an input transfer, OUT_DATA SHALL load the word of channel g, OUT_SEL SHALL load g, and OUT_VALID SHALL be 1 on the next cycle. Latency from input transfer to OUT_VALID is exactly 1 cycle.
REQ-017 With no valid input, when an output transfer occurs, OUT_VALID SHALL go to 0.
REQ-018 With no valid input, when no output transfer occurs, the output register SHALL hold.
REQ-019 Simultaneous output transfer and input transfer SHALL replace the register contents and keep OUT_VALID = 1, giving full throughput of 1 word/cycle.
REQ-020 While OUT_VALID = 1 and OUT_READY = 0, OUT_DATA and OUT_SEL SHALL remain stable and all IN_READY bits SHALL be 0.
REQ-021 A MODE change SHALL take effect in the cycle it is applied; PTR SHALL be preserved across mode changes.
REQ-022 Round-robin SHALL guarantee that a continuously valid channel is granted within N input transfers.

Reset
REQ-023 While RST_N = 0, the block SHALL hold OUT_VALID = 0, OUT_DATA = 0, OUT_SEL = 0 and PTR = 0, and all IN_READY bits SHALL be 0.
REQ-024 Assertion of RST_N SHALL take effect immediately, without waiting for CLK, including mid-transfer.
REQ-025 Any held word SHALL be discarded on reset.
REQ-026 The first grant after deassertion SHALL use PTR = 0.

Verification (N=4, WIDTH=8)
REQ-027 Reset: pulse RST_N low while OUT_VALID = 1 -> OUT_VALID = 0, OUT_SEL = 0, OUT_DATA = 0 before the next edge.
REQ-028 Round-robin fairness: MODE = 0, all IN_VALID = 1, data 0x0A/0x0B/0x0C/0x0D, OUT_READY = 1 -> OUT_SEL sequence 0,1,2,3,0 on consecutive cycles, with OUT_DATA matching each channel.
REQ-029 Wrap/skip: MODE = 0, PTR = 3 after a grant to channel 2, IN_VALID = 4'b0011 -> grant to channel 0, then channel 1.
REQ-030 Fixed priority: MODE = 1, IN_VALID = 4'b1110 held -> OUT_SEL = 1 every cycle; channels 2 and 3 are never granted.
REQ-031 Back-pressure: OUT_READY = 0 for 3 cycles with OUT_VALID = 1 and OUT_DATA = 0x55 -> OUT_DATA stable at 0x55 and IN_READY = 0; on release, the word transfers and the next word loads in the same edge.
REQ-032 Mode switch: MODE 0 -> 1 mid-stream with PTR = 2 -> the next grant goes to the lowest valid channel; switching back to MODE 0 resumes the search from PTR = 2.
